// File: rtl/alphabet_rank_ctrl.sv
// alphabet_rank_ctrl: sequencer that scores one latched sensor vector against
// NUM_LETTERS templates by sum of absolute differences, writes each score to
// the ranking cache and tracks the best (minimum) letter.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   START               run request, sampled only in IDLE
//   SENSOR_IN           sensor vector, channel s at [s*DATA_W +: DATA_W]
//   REF_LETTER/REF_SEL  template ROM address (letter, sensor)
//   REF_DATA            ROM read data, one cycle after the address
//   MEM_CS/MEM_RW_      cache strobe (write when MEM_CS=1, MEM_RW_=0)
//   MEM_ADDR/MEM_DATA   cache address (letter) and score
//   BUSY, DONE          run in progress, end-of-run pulse
//   BEST_ADDR/BEST_SCORE best-matching letter and its score
module alphabet_rank_ctrl #(
   parameter int unsigned NUM_SENSORS = 5,
   parameter int unsigned NUM_LETTERS = 26,
   parameter int unsigned DATA_W      = 12,
   parameter int unsigned SCORE_W     = 15
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          START,
   input  logic [NUM_SENSORS*DATA_W-1:0] SENSOR_IN,
   output logic [5:0]                    REF_LETTER,
   output logic [2:0]                    REF_SEL,
   input  logic [DATA_W-1:0]             REF_DATA,
   output logic                          MEM_CS,
   output logic                          MEM_RW_,
   output logic [5:0]                    MEM_ADDR,
   output logic [SCORE_W-1:0]            MEM_DATA,
   output logic                          BUSY,
   output logic                          DONE,
   output logic [5:0]                    BEST_ADDR,
   output logic [SCORE_W-1:0]            BEST_SCORE
);

   localparam int unsigned LETTER_W = 6;
   localparam int unsigned SEL_W    = 3;
   localparam int unsigned VEC_W    = NUM_SENSORS * DATA_W;

   localparam logic [SEL_W-1:0]    LAST_SENSOR = SEL_W'(NUM_SENSORS - 1);
   localparam logic [LETTER_W-1:0] LAST_LETTER = LETTER_W'(NUM_LETTERS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      ACC   = 3'd2,
      WRITE = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [VEC_W-1:0]      sens_q, sens_d;
   logic [LETTER_W-1:0]   letter_q, letter_d;
   logic [SEL_W-1:0]      sensor_q, sensor_d;
   logic [SCORE_W-1:0]    acc_q, acc_d;
   logic [LETTER_W-1:0]   ref_letter_d;
   logic [SEL_W-1:0]      ref_sel_d;
   logic                  mem_cs_d, mem_rw_d;
   logic [LETTER_W-1:0]   mem_addr_d;
   logic [SCORE_W-1:0]    mem_data_d;
   logic                  busy_d, done_d;
   logic [LETTER_W-1:0]   best_addr_d;
   logic [SCORE_W-1:0]    best_score_d;

   logic [DATA_W-1:0]     s_cur;
   logic [DATA_W-1:0]     abs_diff;
   logic [SCORE_W-1:0]    acc_sum;

   // Per-sensor distance term, computed at sample width then widened.
   always_comb begin
      s_cur    = sens_q[32'(sensor_q) * DATA_W +: DATA_W];
      abs_diff = (s_cur >= REF_DATA) ? (s_cur - REF_DATA) : (REF_DATA - s_cur);
      acc_sum  = acc_q + SCORE_W'(abs_diff);
   end

   // Next-state and next-output logic; outputs are registered one edge
   // ahead so they are valid throughout the state they belong to.
   always_comb begin
      state_d      = state_q;
      sens_d       = sens_q;
      letter_d     = letter_q;
      sensor_d     = sensor_q;
      acc_d        = acc_q;
      ref_letter_d = REF_LETTER;
      ref_sel_d    = REF_SEL;
      mem_cs_d     = 1'b0;
      mem_rw_d     = 1'b1;
      mem_addr_d   = MEM_ADDR;
      mem_data_d   = MEM_DATA;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      best_addr_d  = BEST_ADDR;
      best_score_d = BEST_SCORE;

      unique case (state_q)
         IDLE: begin
            if (START) begin
               sens_d       = SENSOR_IN;
               letter_d     = '0;
               sensor_d     = '0;
               acc_d        = '0;
               best_score_d = '1;
               ref_letter_d = '0;
               ref_sel_d    = '0;
               busy_d       = 1'b1;
               state_d      = FETCH;
            end
         end
         FETCH: begin
            busy_d  = 1'b1;
            state_d = ACC;
         end
         ACC: begin
            busy_d = 1'b1;
            acc_d  = acc_sum;
            if (sensor_q < LAST_SENSOR) begin
               sensor_d     = sensor_q + SEL_W'(1);
               ref_letter_d = letter_q;
               ref_sel_d    = sensor_q + SEL_W'(1);
               state_d      = FETCH;
            end else begin
               mem_cs_d   = 1'b1;
               mem_rw_d   = 1'b0;
               mem_addr_d = letter_q;
               mem_data_d = acc_sum;
               state_d    = WRITE;
            end
         end
         WRITE: begin
            // Strict compare keeps the lower letter on ties.
            if (acc_q < BEST_SCORE) begin
               best_score_d = acc_q;
               best_addr_d  = letter_q;
            end
            if (letter_q < LAST_LETTER) begin
               letter_d     = letter_q + LETTER_W'(1);
               sensor_d     = '0;
               acc_d        = '0;
               ref_letter_d = letter_q + LETTER_W'(1);
               ref_sel_d    = '0;
               busy_d       = 1'b1;
               state_d      = FETCH;
            end else begin
               done_d  = 1'b1;
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         sens_q     <= '0;
         letter_q   <= '0;
         sensor_q   <= '0;
         acc_q      <= '0;
         REF_LETTER <= '0;
         REF_SEL    <= '0;
         MEM_CS     <= 1'b0;
         MEM_RW_    <= 1'b1;
         MEM_ADDR   <= '0;
         MEM_DATA   <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         BEST_ADDR  <= '0;
         BEST_SCORE <= '1;
      end else begin
         state_q    <= state_d;
         sens_q     <= sens_d;
         letter_q   <= letter_d;
         sensor_q   <= sensor_d;
         acc_q      <= acc_d;
         REF_LETTER <= ref_letter_d;
         REF_SEL    <= ref_sel_d;
         MEM_CS     <= mem_cs_d;
         MEM_RW_    <= mem_rw_d;
         MEM_ADDR   <= mem_addr_d;
         MEM_DATA   <= mem_data_d;
         BUSY       <= busy_d;
         DONE       <= done_d;
         BEST_ADDR  <= best_addr_d;
         BEST_SCORE <= best_score_d;
      end
   end

endmodule

// File: tb/tb_alphabet_rank_ctrl.sv
// Testbench for alphabet_rank_ctrl: template ROM and cache models, a table of
// directed scenarios, randomized runs, reset-abort and latch-isolation cases.
module tb_alphabet_rank_ctrl;

   localparam int NS  = 5;
   localparam int NL  = 26;
   localparam int DW  = 12;
   localparam int SW  = 15;
   localparam int RUN = NL * (2 * NS + 1);

   logic              CLK = 1'b0;
   logic              RST_N;
   logic              START;
   logic [NS*DW-1:0]  SENSOR_IN;
   logic [5:0]        REF_LETTER;
   logic [2:0]        REF_SEL;
   logic [DW-1:0]     REF_DATA;
   logic              MEM_CS, MEM_RW_;
   logic [5:0]        MEM_ADDR;
   logic [SW-1:0]     MEM_DATA;
   logic              BUSY, DONE;
   logic [5:0]        BEST_ADDR;
   logic [SW-1:0]     BEST_SCORE;

   alphabet_rank_ctrl #(.NUM_SENSORS(NS), .NUM_LETTERS(NL), .DATA_W(DW), .SCORE_W(SW)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .SENSOR_IN(SENSOR_IN),
      .REF_LETTER(REF_LETTER), .REF_SEL(REF_SEL), .REF_DATA(REF_DATA),
      .MEM_CS(MEM_CS), .MEM_RW_(MEM_RW_), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
      .BUSY(BUSY), .DONE(DONE), .BEST_ADDR(BEST_ADDR), .BEST_SCORE(BEST_SCORE)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   int rom [64][8];
   int sens_v [NS];
   int exp_sc [NL];
   int exp_best_addr, exp_best_score;

   typedef struct { int addr; int data; int rw; } wr_t;
   wr_t wlog [$];
   int  done_q [$];

   // Template ROM with one cycle read latency.
   always @(posedge CLK) REF_DATA <= DW'(rom[REF_LETTER][REF_SEL]);

   // Bus observer: every cache strobe and DONE pulse, sampled mid-cycle.
   always @(negedge CLK) begin
      if (MEM_CS) wlog.push_back('{int'(MEM_ADDR), int'(MEM_DATA), int'(MEM_RW_)});
      if (DONE) done_q.push_back(1);
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: SAD per letter, then first minimum.
   task automatic model();
      exp_best_score = -1;
      exp_best_addr  = 0;
      for (int l = 0; l < NL; l++) begin
         int sum = 0;
         for (int s = 0; s < NS; s++)
            sum += (sens_v[s] > rom[l][s]) ? sens_v[s] - rom[l][s] : rom[l][s] - sens_v[s];
         exp_sc[l] = sum;
         if (exp_best_score < 0 || sum < exp_best_score) begin
            exp_best_score = sum;
            exp_best_addr  = l;
         end
      end
   endtask

   function automatic logic [NS*DW-1:0] pack_sens();
      logic [NS*DW-1:0] v;
      for (int s = 0; s < NS; s++) v[s*DW +: DW] = DW'(sens_v[s]);
      return v;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, " BUSY"}, int'(BUSY), 0);
      check({tag, " DONE"}, int'(DONE), 0);
      check({tag, " MEM_CS"}, int'(MEM_CS), 0);
      check({tag, " MEM_RW_"}, int'(MEM_RW_), 1);
      check({tag, " REF_LETTER"}, int'(REF_LETTER), 0);
      check({tag, " REF_SEL"}, int'(REF_SEL), 0);
      check({tag, " MEM_ADDR"}, int'(MEM_ADDR), 0);
      check({tag, " MEM_DATA"}, int'(MEM_DATA), 0);
      check({tag, " BEST_ADDR"}, int'(BEST_ADDR), 0);
      check({tag, " BEST_SCORE"}, int'(BEST_SCORE), 32767);
   endtask

   // One complete run: START, bounded wait for DONE, then trace and result checks.
   task automatic run(input string tag, input bit perturb);
      int done_e = -1;
      model();
      wlog.delete();
      done_q.delete();
      @(negedge CLK);
      SENSOR_IN = pack_sens();
      START = 1'b1;
      @(posedge CLK);
      for (int e = 0; e < 1000; e++) begin
         @(negedge CLK);
         if (e == 0) begin
            START = 1'b0;
            check({tag, " busy_at_start"}, int'(BUSY), 1);
            if (perturb) SENSOR_IN = ~SENSOR_IN ^ NS*DW'($urandom);
         end
         if (e == 50) START = 1'b1;
         if (e == 51) START = 1'b0;
         if (DONE && done_e < 0) done_e = e;
         if (done_e >= 0 && e == done_e + 1) check({tag, " done_one_cycle"}, int'(DONE), 0);
         if (done_e >= 0 && e == done_e + 3) begin
            check({tag, " idle_after"}, int'(BUSY), 0);
            break;
         end
         @(posedge CLK);
      end
      check({tag, " done_latency"}, done_e, RUN);
      check({tag, " done_pulses"}, done_q.size(), 1);
      check({tag, " write_count"}, wlog.size(), NL);
      for (int i = 0; i < wlog.size() && i < NL; i++) begin
         check($sformatf("%s wr%0d addr", tag, i), wlog[i].addr, i);
         check($sformatf("%s wr%0d data", tag, i), wlog[i].data, exp_sc[i]);
         check($sformatf("%s wr%0d rw", tag, i), wlog[i].rw, 0);
      end
      check({tag, " best_addr"}, int'(BEST_ADDR), exp_best_addr);
      check({tag, " best_score"}, int'(BEST_SCORE), exp_best_score);
   endtask

   typedef struct {
      int s [NS];
      int ta, tb2, toff, ooff;
      bit maxm;
      int ea, es;
   } vec_t;

   vec_t vt [5];

   task automatic build(input int r);
      for (int s = 0; s < NS; s++) sens_v[s] = vt[r].maxm ? 0 : vt[r].s[s];
      for (int l = 0; l < NL; l++)
         for (int s = 0; s < NS; s++) begin
            if (vt[r].maxm) rom[l][s] = 4095;
            else if (s == 0)
               rom[l][s] = sens_v[0] + ((l == vt[r].ta || l == vt[r].tb2) ? vt[r].toff : vt[r].ooff);
            else rom[l][s] = sens_v[s];
         end
   endtask

   initial begin
      RST_N = 1'b0;
      START = 1'b0;
      SENSOR_IN = '0;
      for (int l = 0; l < 64; l++) for (int s = 0; s < 8; s++) rom[l][s] = 0;

      vt[0] = '{s:'{100, 200, 300, 400, 500}, ta:7,  tb2:7,  toff:0,  ooff:1,  maxm:0, ea:7,  es:0};
      vt[1] = '{s:'{1000, 50, 2000, 3000, 7}, ta:3,  tb2:10, toff:40, ooff:41, maxm:0, ea:3,  es:40};
      vt[2] = '{s:'{10, 20, 30, 40, 50},      ta:25, tb2:25, toff:5,  ooff:6,  maxm:0, ea:25, es:5};
      vt[3] = '{s:'{0, 4095, 0, 4095, 1},     ta:0,  tb2:0,  toff:9,  ooff:9,  maxm:0, ea:0,  es:9};
      vt[4] = '{s:'{0, 0, 0, 0, 0},           ta:0,  tb2:0,  toff:0,  ooff:0,  maxm:1, ea:0,  es:20475};

      #12;
      check_reset_vals("por");
      @(negedge CLK);
      RST_N = 1'b1;

      for (int r = 0; r < 5; r++) begin
         build(r);
         run($sformatf("vec%0d", r), 1'b0);
         check($sformatf("vec%0d table_addr", r), int'(BEST_ADDR), vt[r].ea);
         check($sformatf("vec%0d table_score", r), int'(BEST_SCORE), vt[r].es);
      end

      // Randomized runs; the last one also changes SENSOR_IN after the latch edge.
      for (int t = 0; t < 4; t++) begin
         for (int s = 0; s < NS; s++) sens_v[s] = int'($urandom_range(0, 4095));
         for (int l = 0; l < NL; l++)
            for (int s = 0; s < NS; s++) rom[l][s] = int'($urandom_range(0, 4095));
         run($sformatf("rnd%0d", t), t == 3);
      end

      // Asynchronous reset 100 cycles into a run aborts it completely.
      for (int s = 0; s < NS; s++) sens_v[s] = int'($urandom_range(0, 4095));
      @(negedge CLK);
      SENSOR_IN = pack_sens();
      START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      repeat (100) @(posedge CLK);
      #2 RST_N = 1'b0;
      #1 check_reset_vals("midrst");
      wlog.delete();
      done_q.delete();
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (RUN + 20) @(negedge CLK);
      check("midrst no_writes", wlog.size(), 0);
      check("midrst no_done", done_q.size(), 0);
      check("midrst idle", int'(BUSY), 0);
      run("after_rst", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alphabet_rank_ctrl.md
# alphabet_rank_ctrl

Sequencer for the alphabet ranking datapath. On START it latches one sensor vector. For each letter template it fetches the per-sensor reference values from the template ROM, accumulates the sum of absolute differences, and writes each letter's score into the ranking cache memory. It tracks the running minimum and reports the best-matching letter address and its score.

## Interface
Parameters:
- NUM_SENSORS, 5, sensor channels per vector; legal range 1..8
- NUM_LETTERS, 26, templates scored per run; legal range 1..64
- DATA_W, 12, sensor and reference sample width
- SCORE_W, 15, accumulated score width; must be ≥ DATA_W+3

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  run request; sampled only in IDLE
- SENSOR_IN  in  NUM_SENSORS*DATA_W  sensor vector; channel s occupies bits [s*DATA_W +: DATA_W]
- REF_LETTER  out  6  template ROM letter index
- REF_SEL  out  3  template ROM sensor index
- REF_DATA  in  DATA_W  ROM read data; valid the cycle after REF_LETTER/REF_SEL are presented
- MEM_CS  out  1  cache chip select
- MEM_RW_  out  1  cache read/write; 1 = read, 0 = write
- MEM_ADDR  out  6  cache address, equal to the letter index
- MEM_DATA  out  SCORE_W  score written to the cache
- BUSY  out  1  run in progress
- DONE  out  1  one-cycle pulse at end of run
- BEST_ADDR  out  6  letter index with the minimum score
- BEST_SCORE  out  SCORE_W  minimum score

## Operation
- States:
  - IDLE: START=1 latches SENSOR_IN, clears letter, sensor and accumulator to 0, sets BEST_SCORE to all-ones, then goes to FETCH.
  - FETCH: drives REF_LETTER = letter and REF_SEL = sensor, then goes to ACC.
  - ACC: accumulator += |latched[sensor] − REF_DATA|.
    - If sensor < NUM_SENSORS−1: sensor+1, go to FETCH.
    - Otherwise go to WRITE.
  - WRITE: MEM_CS=1, MEM_RW_=0, MEM_ADDR=letter, MEM_DATA=accumulator.
    - If accumulator < BEST_SCORE (strict), load BEST_SCORE and BEST_ADDR.
    - If letter < NUM_LETTERS−1: letter+1, sensor=0, accumulator=0, go to FETCH.
    - Otherwise go to FIN.
  - FIN: DONE=1 for one cycle, then go to IDLE.
- Absolute difference is computed at DATA_W bits as (s ≥ r) ? s−r : r−s, then zero-extended to SCORE_W. With the parameter constraints the sum never overflows; no saturation logic.
- Ties keep the lower letter index, because the comparison is strict.
- BUSY = 1 in FETCH, ACC and WRITE; 0 in IDLE and FIN.
- Outside WRITE: MEM_CS=0, MEM_RW_=1, and MEM_ADDR/MEM_DATA hold their last values.
- REF_LETTER/REF_SEL hold their values outside FETCH.
- START is ignored outside IDLE. SENSOR_IN changes after the latch edge have no effect on the run.
- BEST_ADDR and BEST_SCORE hold from FIN until the next accepted START.
  - At the START edge BEST_SCORE becomes all-ones.
  - BEST_ADDR keeps its old value until the first WRITE.
- Reset values: state IDLE; BUSY, DONE, MEM_CS = 0; MEM_RW_ = 1; REF_LETTER, REF_SEL, MEM_ADDR, MEM_DATA, BEST_ADDR = 0; BEST_SCORE all-ones.
- RST_N low mid-run aborts immediately:
  - No further cache writes.
  - No DONE pulse.
  - Cache contents already written are left as they are.

## Timing
- Each letter takes 2*NUM_SENSORS+1 cycles: one FETCH/ACC pair per sensor, plus one WRITE.
- START accepted at edge k → BUSY high from edge k.
- The last WRITE occupies the cycle after edge k + NUM_LETTERS*(2*NUM_SENSORS+1) − 1.
- DONE is high for the single cycle after edge k + NUM_LETTERS*(2*NUM_SENSORS+1). With defaults this is edge k+286.
- A new START is accepted no earlier than the edge that returns FIN to IDLE, plus one cycle.
- ROM read latency is exactly 1 cycle. REF_DATA is sampled only in ACC.

## Test plan
- **Exact match.** Templates in which letter 7 equals SENSOR_IN = {100,200,300,400,500}, all other letters differ by ≥1 → BEST_ADDR=7, BEST_SCORE=0, cache[7]=0, DONE at k+286.
- **Tie.** Letters 3 and 10 both score 40, all others > 40 → BEST_ADDR=3, BEST_SCORE=40.
- **Maximum difference.** Sensors all 0, every reference 4095 → every cache write is 20475 with no wrap; BEST_ADDR=0.
- **Write trace.** Exactly 26 cycles with MEM_CS=1 and MEM_RW_=0; MEM_ADDR 0..25 in order; each MEM_DATA equals the model's sum of absolute differences; START pulsed while BUSY=1 has no effect.
- **Reset mid-run.** RST_N=0 asynchronously after 100 cycles → all outputs take their reset values at once, no DONE follows; the next START completes a full, correct run.
- **Latch isolation.** SENSOR_IN changed on the cycle after the START edge → scores match the vector latched at the START edge.
